// File: rtl/svc_vga_monitor.sv
// -----------------------------------------------------------------------------
// svc_vga_monitor
//
// Passive sink for a VGA pixel stream. It recovers horizontal and vertical
// timing from hsync/vsync, locks to the frame structure, regenerates visible
// pixel coordinates and reports timing and blanking violations.
//
// Pipeline: every input is registered once (stage 1). All detection works on
// the stage-1 copies, and every output is registered again. Outputs therefore
// appear 2 clocks after the inputs are sampled.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset; every output is 0 while low
//   vga_red/grn/blu, vga_hsync, vga_vsync   incoming VGA stream
//   locked       timing locked (state == LOCKED)
//   pixel_valid  pixel_x/pixel_y/colour describe a visible pixel
//   pixel_x/y    visible column/row; they hold while pixel_valid is low
//   pixel_red/grn/blu  captured colour, updated every cycle
//   frame_done   one-cycle pulse at each frame start while locked
//   err_line     pulse: hsync width or line length mismatch
//   err_frame    pulse: vsync width or frame length mismatch
//   err_blank    pulse: non-zero colour during blanking while locked
//   err_cnt      saturating count of cycles with any err_* asserted
// -----------------------------------------------------------------------------
module svc_vga_monitor #(
    parameter int COLOR_WIDTH = 4,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int SYNC_POL    = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [COLOR_WIDTH-1:0]       vga_red,
    input  logic [COLOR_WIDTH-1:0]       vga_grn,
    input  logic [COLOR_WIDTH-1:0]       vga_blu,
    input  logic                         vga_hsync,
    input  logic                         vga_vsync,
    output logic                         locked,
    output logic                         pixel_valid,
    output logic [$clog2(H_VISIBLE)-1:0] pixel_x,
    output logic [$clog2(V_VISIBLE)-1:0] pixel_y,
    output logic [COLOR_WIDTH-1:0]       pixel_red,
    output logic [COLOR_WIDTH-1:0]       pixel_grn,
    output logic [COLOR_WIDTH-1:0]       pixel_blu,
    output logic                         frame_done,
    output logic                         err_line,
    output logic                         err_frame,
    output logic                         err_blank,
    output logic [15:0]                  err_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int XW      = $clog2(H_VISIBLE);
    localparam int YW      = $clog2(V_VISIBLE);

    localparam logic          SYNC_ACT  = (SYNC_POL != 0);
    localparam logic [HW-1:0] H_SYNC_C  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_VIS_LO  = HW'(H_SYNC + H_BACK);
    localparam logic [HW-1:0] H_VIS_HI  = HW'(H_SYNC + H_BACK + H_VISIBLE - 1);
    localparam logic [HW:0]   H_TOTAL_C = (HW + 1)'(H_TOTAL);
    localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_VIS_LO  = VW'(V_SYNC + V_BACK);
    localparam logic [VW-1:0] V_VIS_HI  = VW'(V_SYNC + V_BACK + V_VISIBLE - 1);
    localparam logic [VW:0]   V_TOTAL_C = (VW + 1)'(V_TOTAL);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Stage-1 input copies
    logic [COLOR_WIDTH-1:0] in_red, in_grn, in_blu;
    logic                   in_hs, in_vs;

    // Timing recovery state
    logic          hs_act_d;   // hs_act of the previous registered cycle
    logic          vs_at_ls;   // vs_act sampled at the previous line start
    logic [HW-1:0] h_q;        // h_cnt of the previous registered cycle
    logic [VW-1:0] v_q;        // v_cnt of the current line

    // Lock state machine
    state_t state;
    logic   meas_armed;        // a measurement window is open (began at a frame start)
    logic   meas_err;          // an error was seen inside the open window

    // Combinational view of the current registered cycle
    logic          hs_act, vs_act;
    logic          line_start, hs_drop, frame_start, vs_drop;
    logic [HW-1:0] h_cur;
    logic [VW-1:0] v_cur;
    logic [HW:0]   h_len;
    logic [VW:0]   v_len;
    logic          line_err, frame_err, err_any;
    logic          visible;

    state_t state_nxt;
    logic   armed_nxt, meas_err_nxt, frame_done_nxt;
    logic   lock_nxt, pix_valid_nxt;
    logic   err_line_nxt, err_frame_nxt, err_blank_nxt;

    assign hs_act      = (in_hs == SYNC_ACT);
    assign vs_act      = (in_vs == SYNC_ACT);
    assign line_start  = hs_act & ~hs_act_d;
    assign hs_drop     = ~hs_act & hs_act_d;
    assign frame_start = line_start & vs_act & ~vs_at_ls;
    assign vs_drop     = line_start & ~vs_act & vs_at_ls;

    // Length of the line/frame that ends here, taken from the pre-reset count.
    // One extra bit keeps a saturated counter from aliasing onto the total.
    assign h_len = {1'b0, h_q} + 1'b1;
    assign v_len = {1'b0, v_q} + 1'b1;

    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        h_cur = h_q;
        if (line_start) begin
            h_cur = '0;
        end else if (!(&h_q)) begin
            h_cur = h_q + 1'b1;
        end

        v_cur = v_q;
        if (frame_start) begin
            v_cur = '0;
        end else if (line_start && !(&v_q)) begin
            v_cur = v_q + 1'b1;
        end
    end

    assign line_err  = (hs_drop && (h_cur != H_SYNC_C)) ||
                       (line_start && (h_len != H_TOTAL_C));
    assign frame_err = (vs_drop && (v_cur != V_SYNC_C)) ||
                       (frame_start && (v_len != V_TOTAL_C));
    assign err_any   = line_err | frame_err;

    assign visible = (h_cur >= H_VIS_LO) && (h_cur <= H_VIS_HI) &&
                     (v_cur >= V_VIS_LO) && (v_cur <= V_VIS_HI);

    // Lock decisions. A measurement window always spans frame start to frame
    // start; after losing lock the monitor first waits for a frame start to
    // open a fresh window, so relock needs two clean frame starts.
    always_comb begin
        state_nxt      = state;
        armed_nxt      = meas_armed;
        meas_err_nxt   = meas_err;
        frame_done_nxt = 1'b0;
        case (state)
            SEARCH: begin
                if (frame_start) begin
                    state_nxt    = MEASURE;
                    armed_nxt    = 1'b1;
                    meas_err_nxt = 1'b0;
                end
            end
            MEASURE: begin
                if (frame_start) begin
                    if (meas_armed && !meas_err && !err_any) begin
                        state_nxt      = LOCKED;
                        frame_done_nxt = 1'b1;
                    end else begin
                        armed_nxt    = 1'b1;
                        meas_err_nxt = 1'b0;
                    end
                end else if (err_any) begin
                    meas_err_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (err_any) begin
                    state_nxt    = MEASURE;
                    armed_nxt    = 1'b0;
                    meas_err_nxt = 1'b0;
                end else if (frame_start) begin
                    frame_done_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

    // Errors are suppressed while searching; blanking errors only count once
    // the output reports lock, so locked and err_blank never disagree.
    assign lock_nxt      = (state_nxt == LOCKED);
    assign pix_valid_nxt = lock_nxt & visible;
    assign err_line_nxt  = line_err  & (state != SEARCH);
    assign err_frame_nxt = frame_err & (state != SEARCH);
    assign err_blank_nxt = lock_nxt & ~visible & (|{in_red, in_grn, in_blu});

    // Input stage and timing counters.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_red   <= '0;
            in_grn   <= '0;
            in_blu   <= '0;
            in_hs    <= ~SYNC_ACT;
            in_vs    <= ~SYNC_ACT;
            hs_act_d <= 1'b0;
            vs_at_ls <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
        end else begin
            in_red   <= vga_red;
            in_grn   <= vga_grn;
            in_blu   <= vga_blu;
            in_hs    <= vga_hsync;
            in_vs    <= vga_vsync;
            hs_act_d <= hs_act;
            h_q      <= h_cur;
            v_q      <= v_cur;
            if (line_start) begin
                vs_at_ls <= vs_act;
            end
        end
    end

    // State machine and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SEARCH;
            meas_armed  <= 1'b0;
            meas_err    <= 1'b0;
            locked      <= 1'b0;
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_red   <= '0;
            pixel_grn   <= '0;
            pixel_blu   <= '0;
            frame_done  <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            err_blank   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state       <= state_nxt;
            meas_armed  <= armed_nxt;
            meas_err    <= meas_err_nxt;
            locked      <= lock_nxt;
            pixel_valid <= pix_valid_nxt;
            if (pix_valid_nxt) begin
                pixel_x <= XW'(h_cur - H_VIS_LO);
                pixel_y <= YW'(v_cur - V_VIS_LO);
            end
            pixel_red   <= in_red;
            pixel_grn   <= in_grn;
            pixel_blu   <= in_blu;
            frame_done  <= frame_done_nxt;
            err_line    <= err_line_nxt;
            err_frame   <= err_frame_nxt;
            err_blank   <= err_blank_nxt;
            if ((err_line_nxt || err_frame_nxt || err_blank_nxt) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_svc_vga_monitor.sv
`timescale 1ns/1ps
// Bench for svc_vga_monitor on a reduced raster (15 x 11 clocks per frame)
// so full frames stay short.
module tb_svc_vga_monitor;

    localparam int CW = 4;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 15
    localparam int VT = VV + VF + VS + VB;   // 11
    localparam int XW = $clog2(HV);
    localparam int YW = $clog2(VV);
    localparam logic SP = 1'b0;              // sync active level

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] vga_red = '0, vga_grn = '0, vga_blu = '0;
    logic          vga_hsync = ~SP, vga_vsync = ~SP;
    logic          locked, pixel_valid, frame_done, err_line, err_frame, err_blank;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic [CW-1:0] pixel_red, pixel_grn, pixel_blu;
    logic [15:0]   err_cnt;

    svc_vga_monitor #(
        .COLOR_WIDTH(CW), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_red(vga_red), .vga_grn(vga_grn), .vga_blu(vga_blu),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .locked(locked), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pixel_red(pixel_red), .pixel_grn(pixel_grn), .pixel_blu(pixel_blu),
        .frame_done(frame_done), .err_line(err_line), .err_frame(err_frame),
        .err_blank(err_blank), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pix_t;

    typedef struct packed {
        logic        fd;
        logic        el;
        logic        ef;
        logic        eb;
        logic        lk;
        logic [15:0] cnt;
    } ev_t;

    pix_t pq[$];
    ev_t  evq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sat_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic ev_t mk_ev(input logic fd, el, ef, eb, lk, input logic [15:0] cnt);
        ev_t e;
        e.fd = fd; e.el = el; e.ef = ef; e.eb = eb; e.lk = lk; e.cnt = cnt;
        return e;
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({locked, pixel_valid, pixel_x, pixel_y, pixel_red, pixel_grn, pixel_blu,
                    frame_done, err_line, err_frame, err_blank, err_cnt});
    endfunction

    // Monitor: pops an expected pixel whenever pixel_valid is seen and an
    // expected event record whenever any pulse output is seen.
    initial begin
        pix_t pe, pa;
        ev_t  ee, ea;
        forever begin
            @(negedge clk);
            if (rst_n && !sat_mode) begin
                if (pixel_valid) begin
                    check("pixel_expected", 64'(pq.size() != 0), 64'd1);
                    if (pq.size() != 0) begin
                        pe = pq.pop_front();
                        pa = {8'(pixel_x), 8'(pixel_y), pixel_red, pixel_grn, pixel_blu};
                        check("pixel", 64'(pa), 64'(pe));
                    end
                end
                if (frame_done || err_line || err_frame || err_blank) begin
                    check("event_expected", 64'(evq.size() != 0), 64'd1);
                    if (evq.size() != 0) begin
                        ee = evq.pop_front();
                        ea = mk_ev(frame_done, err_line, err_frame, err_blank, locked, err_cnt);
                        check("event", 64'(ea), 64'(ee));
                    end
                end
            end
        end
    end

    // One stream cycle: drive, then step past the next rising edge.
    task automatic drive(input logic hs_a, input logic vs_a,
                         input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        vga_hsync = hs_a ? SP : ~SP;
        vga_vsync = vs_a ? SP : ~SP;
        vga_red   = r;
        vga_grn   = g;
        vga_blu   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1 check("reset_outputs_zero", all_outputs(), 64'd0);
        sat_mode = 1'b0;
        pq.delete();
        evq.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One frame. Row order: vsync lines, back porch, visible, front porch.
    // Column order: hsync, back porch, visible, front porch.
    // Visible colour is {x, y, 5}; blanking is 0 except the optional blank pixel.
    task automatic send_frame(input int long_line, input int short_line, input int vs_lines,
                              input int blank_v, input int blank_h, input int reset_at,
                              input bit exp_lock);
        int idx = 0;
        for (int v = 0; v < VT; v++) begin
            int len = (v == long_line) ? HT + 1 : HT;
            int hsw = (v == short_line) ? HS - 1 : HS;
            for (int h = 0; h < len; h++) begin
                bit vis;
                int x, y;
                logic [3:0] r, g, b;
                vis = (h >= HS + HB) && (h < HS + HB + HV) && (v >= VS + VB) && (v < VS + VB + VV);
                x = h - (HS + HB);
                y = v - (VS + VB);
                if (vis) begin
                    r = 4'(x); g = 4'(y); b = 4'h5;
                    if (exp_lock) pq.push_back({8'(x), 8'(y), 4'(x), 4'(y), 4'h5});
                end else begin
                    r = (v == blank_v && h == blank_h) ? 4'h1 : 4'h0;
                    g = 4'h0; b = 4'h0;
                end
                if (idx == reset_at) mid_reset();
                drive(h < hsw, v < vs_lines, r, g, b);
                idx++;
            end
        end
    endtask

    task automatic clean_frame(input bit exp_lock);
        send_frame(-1, -1, VS, -1, -1, -1, exp_lock);
    endtask

    task automatic reset_dut();
        vga_hsync = ~SP; vga_vsync = ~SP;
        vga_red = '0; vga_grn = '0; vga_blu = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Let the pipeline empty, then every expectation must have been consumed.
    task automatic drain(input string tag);
        repeat (4) drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        check({tag, "_events_drained"}, 64'(evq.size()), 64'd0);
        check({tag, "_pixels_drained"}, 64'(pq.size()), 64'd0);
    endtask

    // Lock from reset: first frame start opens the window, second one locks.
    task automatic relock(input logic [15:0] cnt);
        clean_frame(1'b0);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, cnt));
        clean_frame(1'b1);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 check("reset_state", all_outputs(), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean frames: lock at 2nd frame start, pixels from (0,0) to (7,5)
        relock(16'd0);
        check("locked_after_two_frames", 64'(locked), 64'd1);
        check("err_cnt_clean", 64'(err_cnt), 64'd0);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd0));
        clean_frame(1'b1);

        // Line 1 lengthened by one clock: error at line 2 start, relock 2 frames later
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd0));
        evq.push_back(mk_ev(0, 1, 0, 0, 0, 16'd1));
        send_frame(1, -1, VS, -1, -1, -1, 1'b0);
        check("unlocked_after_long_line", 64'(locked), 64'd0);
        clean_frame(1'b0);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd1));
        clean_frame(1'b1);
        check("err_cnt_long_line", 64'(err_cnt), 64'd1);
        drain("long_line");

        // Short hsync, then vsync held three lines
        reset_dut();
        relock(16'd0);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd0));
        evq.push_back(mk_ev(0, 1, 0, 0, 0, 16'd1));
        send_frame(-1, 1, VS, -1, -1, -1, 1'b0);
        clean_frame(1'b0);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd1));
        clean_frame(1'b1);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd1));
        evq.push_back(mk_ev(0, 0, 1, 0, 0, 16'd2));
        send_frame(-1, -1, VS + 1, -1, -1, -1, 1'b0);
        clean_frame(1'b0);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd2));
        clean_frame(1'b1);
        check("err_cnt_sync_width", 64'(err_cnt), 64'd2);
        drain("sync_width");

        // Non-zero red in the front porch of a visible row: one err_blank, lock kept
        reset_dut();
        relock(16'd0);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd0));
        evq.push_back(mk_ev(0, 0, 0, 1, 1, 16'd1));
        send_frame(-1, -1, VS, 5, HS + HB + HV, -1, 1'b1);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd1));
        clean_frame(1'b1);
        check("locked_after_blank", 64'(locked), 64'd1);
        check("err_cnt_blank", 64'(err_cnt), 64'd1);
        drain("blank");

        // hsync toggling every cycle gives an error every cycle: err_cnt saturates
        sat_mode = 1'b1;
        for (int i = 0; i < 65540; i++) drive(i % 2 == 0, 1'b0, 4'h0, 4'h0, 4'h0);
        repeat (3) drive(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        check("err_cnt_saturated", 64'(err_cnt), 64'hFFFF);
        check("unlocked_while_toggling", 64'(locked), 64'd0);

        // Asynchronous reset mid-frame; the first frame after release is never flagged
        send_frame(-1, -1, VS, -1, -1, 80, 1'b0);
        clean_frame(1'b0);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd0));
        clean_frame(1'b1);
        evq.push_back(mk_ev(1, 0, 0, 0, 1, 16'd0));
        clean_frame(1'b1);
        check("err_cnt_after_reset", 64'(err_cnt), 64'd0);
        drain("mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
